// File: rtl/llc_cmd_sequencer.sv
// LLC command sequencer: runs one trace command at a time against an external
// tag/MESI array, issuing bus operations and reporting its own snoop result.
module llc_cmd_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int WAY_W    = 4,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_code,
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic               arr_rd_en,
  output logic [INDEX_W-1:0] arr_index,
  output logic [TAG_W-1:0]   arr_tag,
  input  logic               arr_hit,
  input  logic [WAY_W-1:0]   arr_hit_way,
  input  logic [1:0]         arr_hit_state,
  input  logic [WAY_W-1:0]   arr_vic_way,
  input  logic [1:0]         arr_vic_state,
  input  logic [TAG_W-1:0]   arr_vic_tag,
  output logic               arr_wr_en,
  output logic [WAY_W-1:0]   arr_wr_way,
  output logic [TAG_W-1:0]   arr_wr_tag,
  output logic [1:0]         arr_wr_state,
  output logic               arr_clr_en,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic [2:0]         bus_op,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic               snp_valid,
  output logic [1:0]         snp_result,
  output logic               print_req,
  input  logic               print_done,
  output logic               done,
  output logic               err,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_DECIDE, S_WB, S_BUSOP, S_UPDATE, S_CLEAR, S_PRINT
  } state_t;

  localparam logic [3:0] C_RD = 4'd0, C_WR = 4'd1, C_IF = 4'd2, C_SINV = 4'd3,
                         C_SRD = 4'd4, C_SWR = 4'd5, C_SRWIM = 4'd6,
                         C_CLR = 4'd8, C_PRT = 4'd9;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [2:0] OP_NONE = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2,
                         OP_INV = 3'd3, OP_RWIM = 3'd4;
  localparam logic [1:0] R_HIT = 2'd0, R_HITM = 2'd1, R_NOHIT = 2'd2;

  state_t               r_state, w_nxt;
  logic [3:0]           r_code;
  logic [ADDR_W-1:0]    r_addr;
  logic [TAG_W-1:0]     r_wb_tag;
  logic [2:0]           r_op;
  logic                 r_wr_do;
  logic [WAY_W-1:0]     r_wr_way;
  logic [TAG_W-1:0]     r_wr_tag;
  logic [1:0]           r_wr_st;
  logic [INDEX_W-1:0]   r_clr_idx;
  logic                 r_err;
  logic                 r_run;

  logic [TAG_W-1:0]     w_tag;
  logic [INDEX_W-1:0]   w_index;
  logic                 w_accept, w_legal, w_clr_last, w_is_snp;
  logic                 w_hit, w_wb, w_wr_do;
  logic [TAG_W-1:0]     w_wb_tag;
  logic [2:0]           w_op;
  logic [WAY_W-1:0]     w_wr_way;
  logic [1:0]           w_wr_st, w_fill, w_snp;
  logic                 w_unused_addr;

  assign w_tag         = r_addr[ADDR_W-1 -: TAG_W];
  assign w_index       = r_addr[OFFSET_W +: INDEX_W];
  assign w_accept      = (r_state == S_IDLE) && r_run && cmd_valid;
  assign w_legal       = (cmd_code <= C_SRWIM) || (cmd_code == C_CLR) || (cmd_code == C_PRT);
  assign w_clr_last    = &r_clr_idx;
  assign w_is_snp      = (r_code >= C_SINV) && (r_code <= C_SRWIM);
  assign w_unused_addr = ^{r_addr[OFFSET_W-1:2], r_addr[0]};

  // Lookup decision; array results are only meaningful while in DECIDE
  always_comb begin
    w_hit    = arr_hit && (arr_hit_state != ST_I);
    w_fill   = r_addr[1] ? ST_E : ST_S;  // other caches: 00 HIT, 01 HITM -> S, else E
    w_snp    = !w_hit ? R_NOHIT : ((arr_hit_state == ST_M) ? R_HITM : R_HIT);
    w_wb     = 1'b0;
    w_wb_tag = arr_vic_tag;
    w_op     = OP_NONE;
    w_wr_do  = 1'b0;
    w_wr_way = arr_hit_way;
    w_wr_st  = arr_hit_state;
    case (r_code)
      C_RD, C_IF: begin
        w_wr_do = 1'b1;
        if (!w_hit) begin
          w_wb     = (arr_vic_state == ST_M);
          w_op     = OP_READ;
          w_wr_way = arr_vic_way;
          w_wr_st  = w_fill;
        end
      end
      C_WR: begin
        w_wr_do = 1'b1;
        w_wr_st = ST_M;
        if (w_hit) begin
          if (arr_hit_state == ST_S) w_op = OP_INV;
        end else begin
          w_wb     = (arr_vic_state == ST_M);
          w_op     = OP_RWIM;
          w_wr_way = arr_vic_way;
        end
      end
      C_SINV: begin
        if (w_hit && (arr_hit_state == ST_S)) begin
          w_wr_do = 1'b1;
          w_wr_st = ST_I;
        end
      end
      C_SRD: begin
        if (w_hit && (arr_hit_state != ST_S)) begin
          w_wr_do  = 1'b1;
          w_wr_st  = ST_S;
          w_wb     = (arr_hit_state == ST_M);
          w_wb_tag = w_tag;
        end
      end
      C_SRWIM: begin
        if (w_hit) begin
          w_wr_do  = 1'b1;
          w_wr_st  = ST_I;
          w_wb     = (arr_hit_state == ST_M);
          w_wb_tag = w_tag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_code <= C_SRWIM)    w_nxt = S_LOOKUP;
          else if (cmd_code == C_CLR) w_nxt = S_CLEAR;
          else if (cmd_code == C_PRT) w_nxt = S_PRINT;
        end
      end
      S_LOOKUP: w_nxt = S_DECIDE;
      S_DECIDE: begin
        if (w_wb)                 w_nxt = S_WB;
        else if (w_op != OP_NONE) w_nxt = S_BUSOP;
        else                      w_nxt = S_UPDATE;
      end
      S_WB:     if (bus_ready) w_nxt = (r_op != OP_NONE) ? S_BUSOP : S_UPDATE;
      S_BUSOP:  if (bus_ready) w_nxt = S_UPDATE;
      S_UPDATE: w_nxt = S_IDLE;
      S_CLEAR:  if (w_clr_last) w_nxt = S_IDLE;
      S_PRINT:  if (print_done) w_nxt = S_UPDATE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Command latch, DECIDE capture and clear-walk counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= '0;
      r_addr    <= '0;
      r_wb_tag  <= '0;
      r_op      <= OP_NONE;
      r_wr_do   <= 1'b0;
      r_wr_way  <= '0;
      r_wr_tag  <= '0;
      r_wr_st   <= ST_I;
      r_clr_idx <= '0;
      r_err     <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_err <= w_accept && !w_legal;
      if (w_accept) begin
        r_code    <= cmd_code;
        r_addr    <= cmd_addr;
        r_wr_do   <= 1'b0;
        r_clr_idx <= '0;
      end
      if (r_state == S_DECIDE) begin
        r_wb_tag <= w_wb_tag;
        r_op     <= w_op;
        r_wr_do  <= w_wr_do;
        r_wr_way <= w_wr_way;
        r_wr_tag <= w_tag;
        r_wr_st  <= w_wr_st;
      end
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    cmd_ready    = (r_state == S_IDLE) && r_run;
    arr_rd_en    = (r_state == S_LOOKUP);
    arr_index    = (r_state == S_CLEAR) ? r_clr_idx : w_index;
    arr_tag      = w_tag;
    arr_wr_en    = (r_state == S_UPDATE) && r_wr_do;
    arr_wr_way   = r_wr_way;
    arr_wr_tag   = r_wr_tag;
    arr_wr_state = r_wr_st;
    arr_clr_en   = (r_state == S_CLEAR);
    bus_valid    = (r_state == S_WB) || (r_state == S_BUSOP);
    bus_op       = OP_NONE;
    bus_addr     = '0;
    if (r_state == S_WB) begin
      bus_op   = OP_WRITE;
      bus_addr = {r_wb_tag, w_index, {OFFSET_W{1'b0}}};
    end else if (r_state == S_BUSOP) begin
      bus_op   = r_op;
      bus_addr = {w_tag, w_index, {OFFSET_W{1'b0}}};
    end
    snp_valid  = (r_state == S_DECIDE) && w_is_snp;
    snp_result = snp_valid ? w_snp : 2'd0;
    print_req  = (r_state == S_PRINT);
    done       = r_err || (r_state == S_UPDATE) || ((r_state == S_CLEAR) && w_clr_last);
    err        = r_err;
    busy       = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_llc_cmd_sequencer.sv
// Randomized bench for llc_cmd_sequencer: the bench plays the tag array, bus and
// printer, and predicts each command's bus ops, line write and snoop reply.
module tb_llc_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        arr_rd_en;
  logic [13:0] arr_index;
  logic [11:0] arr_tag;
  logic        arr_hit;
  logic [3:0]  arr_hit_way;
  logic [1:0]  arr_hit_state;
  logic [3:0]  arr_vic_way;
  logic [1:0]  arr_vic_state;
  logic [11:0] arr_vic_tag;
  logic        arr_wr_en;
  logic [3:0]  arr_wr_way;
  logic [11:0] arr_wr_tag;
  logic [1:0]  arr_wr_state;
  logic        arr_clr_en;
  logic        bus_valid, bus_ready;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic        snp_valid;
  logic [1:0]  snp_result;
  logic        print_req, print_done;
  logic        done, err, busy;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [2:0] READ = 3'd1, WRITE = 3'd2, INVAL = 3'd3, RWIM = 3'd4;
  localparam logic [1:0] MI = 2'd0, MS = 2'd1, ME = 2'd2, MM = 2'd3;

  llc_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
    .arr_rd_en(arr_rd_en), .arr_index(arr_index), .arr_tag(arr_tag),
    .arr_hit(arr_hit), .arr_hit_way(arr_hit_way), .arr_hit_state(arr_hit_state),
    .arr_vic_way(arr_vic_way), .arr_vic_state(arr_vic_state), .arr_vic_tag(arr_vic_tag),
    .arr_wr_en(arr_wr_en), .arr_wr_way(arr_wr_way), .arr_wr_tag(arr_wr_tag),
    .arr_wr_state(arr_wr_state), .arr_clr_en(arr_clr_en),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr),
    .snp_valid(snp_valid), .snp_result(snp_result),
    .print_req(print_req), .print_done(print_done),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_ready, arr_rd_en, arr_index, arr_tag, arr_wr_en, arr_wr_way, arr_wr_tag,
             arr_wr_state, arr_clr_en, bus_valid, bus_op, bus_addr, snp_valid, snp_result,
             print_req, done, err, busy};
  endfunction

  task automatic run_cmd(input string nm, input logic [3:0] code, input logic [31:0] addr,
                         input logic hit, input logic [1:0] hst, input logic [3:0] hway,
                         input logic [1:0] vst, input logic [3:0] vway, input logic [11:0] vtag,
                         input int rdy_after);
    logic [11:0] tg;
    logic [13:0] ix;
    logic [31:0] ln;
    logic        vh, ewr, esv, eerr, erd;
    logic [1:0]  esr, nst, fill;
    logic [3:0]  ewy;
    logic [1:0]  est;
    logic [2:0]  eop[4];
    logic [31:0] ead[4];
    int          ebn;
    logic [2:0]  gop[4];
    logic [31:0] gad[4];
    int          nb, nrd, nwr, nclr, nsnp, nerr, npr, nexcl, nunst, cyc, dcyc;
    logic        got_done, pend;
    logic [2:0]  p_op;
    logic [31:0] p_ad;
    logic [13:0] rd_ix;
    logic [11:0] rd_tg;
    logic [3:0]  g_wy;
    logic [11:0] g_tg;
    logic [1:0]  g_st, g_snp;

    // Reference: what a MESI LLC must do for this command and array state
    tg = addr[31:20]; ix = addr[19:6]; ln = {addr[31:6], 6'b0};
    vh = hit && (hst != MI);
    fill = (addr[1:0] < 2) ? MS : ME;
    ebn = 0; ewr = 0; esv = 0; esr = 0; ewy = 0; est = 0;
    erd  = (code <= 6);
    eerr = !(code <= 6 || code == 9);
    if (code == 0 || code == 2) begin
      ewr = 1;
      if (vh) begin ewy = hway; est = hst; end
      else begin
        if (vst == MM) begin eop[ebn] = WRITE; ead[ebn] = {vtag, ix, 6'b0}; ebn++; end
        eop[ebn] = READ; ead[ebn] = ln; ebn++;
        ewy = vway; est = fill;
      end
    end else if (code == 1) begin
      ewr = 1; est = MM;
      if (vh) begin
        ewy = hway;
        if (hst == MS) begin eop[ebn] = INVAL; ead[ebn] = ln; ebn++; end
      end else begin
        if (vst == MM) begin eop[ebn] = WRITE; ead[ebn] = {vtag, ix, 6'b0}; ebn++; end
        eop[ebn] = RWIM; ead[ebn] = ln; ebn++;
        ewy = vway;
      end
    end else if (code >= 3 && code <= 6) begin
      esv = 1;
      esr = !vh ? 2'd2 : ((hst == MM) ? 2'd1 : 2'd0);
      nst = hst;
      if (vh) begin
        if (code == 3 && hst == MS) nst = MI;
        if (code == 4) nst = MS;
        if (code == 6) nst = MI;
        if (hst == MM && (code == 4 || code == 6)) begin
          eop[ebn] = WRITE; ead[ebn] = ln; ebn++;
        end
      end
      if (vh && nst != hst) begin ewr = 1; ewy = hway; est = nst; end
    end

    arr_hit = hit; arr_hit_state = hst; arr_hit_way = hway;
    arr_vic_state = vst; arr_vic_way = vway; arr_vic_tag = vtag;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_code = code; cmd_addr = addr;
    @(negedge clk);
    chk({nm, "/idle_ready"}, {busy, cmd_ready}, 2'b01);
    @(posedge clk); #1;
    cmd_valid = 1'b0; bus_ready = 1'b0;
    nb = 0; nrd = 0; nwr = 0; nclr = 0; nsnp = 0; nerr = 0; npr = 0; nexcl = 0; nunst = 0;
    cyc = 0; dcyc = 0; got_done = 0; pend = 0; p_op = 0; p_ad = 0;
    rd_ix = 0; rd_tg = 0; g_wy = 0; g_tg = 0; g_st = 0; g_snp = 0;
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (int'(arr_rd_en) + int'(arr_wr_en) + int'(arr_clr_en) > 1) nexcl++;
      if (arr_rd_en) begin nrd++; rd_ix = arr_index; rd_tg = arr_tag; end
      if (arr_wr_en) begin nwr++; g_wy = arr_wr_way; g_tg = arr_wr_tag; g_st = arr_wr_state; end
      if (arr_clr_en) nclr++;
      if (snp_valid) begin nsnp++; g_snp = snp_result; end
      if (err) nerr++;
      if (print_req) npr++;
      if (bus_valid) begin
        if (pend && (bus_op != p_op || bus_addr != p_ad)) nunst++;
        if (bus_ready) begin
          if (nb < 4) begin gop[nb] = bus_op; gad[nb] = bus_addr; end
          nb++; pend = 0;
        end else begin
          pend = 1; p_op = bus_op; p_ad = bus_addr;
        end
      end else if (pend) begin
        nunst++; pend = 0;
      end
      if (done) begin got_done = 1; dcyc = cyc; end
      @(posedge clk); #1;
      bus_ready  = (cyc >= rdy_after) && ($urandom_range(0, 2) == 0);
      print_done = (npr >= 4);
    end
    bus_ready = 1'b0; print_done = 1'b0;

    chk({nm, "/done_seen"}, got_done, 1'b1);
    chk({nm, "/rd_cnt"}, nrd, erd);
    if (erd && nrd == 1) chk({nm, "/lookup"}, {rd_ix, rd_tg}, {ix, tg});
    chk({nm, "/bus_cnt"}, nb, ebn);
    for (int i = 0; i < ebn && i < nb; i++) begin
      chk($sformatf("%s/bus%0d_op", nm, i), gop[i], eop[i]);
      chk($sformatf("%s/bus%0d_addr", nm, i), gad[i], ead[i]);
    end
    chk({nm, "/wr_cnt"}, nwr, ewr);
    if (ewr && nwr == 1) chk({nm, "/wr_line"}, {g_wy, g_tg, g_st}, {ewy, tg, est});
    chk({nm, "/snp_cnt"}, nsnp, esv);
    if (esv && nsnp == 1) chk({nm, "/snp_res"}, g_snp, esr);
    chk({nm, "/err_cnt"}, nerr, eerr);
    chk({nm, "/clr_cnt"}, nclr, 0);
    chk({nm, "/excl"}, nexcl, 0);
    chk({nm, "/bus_stable"}, nunst, 0);
    chk({nm, "/print_cnt"}, npr, (code == 9) ? 5 : 0);
    if (erd && ebn == 0) chk({nm, "/latency"}, dcyc, 3);
    if (eerr) chk({nm, "/err_latency"}, dcyc, 1);
    @(negedge clk);
    chk({nm, "/single_done"}, {done, busy}, 2'b00);
  endtask

  task automatic run_clear(input string nm, input int abort_at);
    int   cyc, exp_ix, bad, ndone, other;
    logic last_ok, aborted;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_code = 4'd8; cmd_addr = $urandom;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0; exp_ix = 0; bad = 0; ndone = 0; other = 0; last_ok = 0; aborted = 0;
    while (ndone == 0 && !aborted && cyc < 17000) begin
      @(negedge clk);
      cyc++;
      if (arr_rd_en || arr_wr_en || bus_valid) other++;
      if (arr_clr_en) begin
        if (arr_index != exp_ix[13:0]) bad++;
        exp_ix++;
      end
      if (done) begin
        ndone++;
        last_ok = arr_clr_en && (arr_index == 14'h3FFF);
      end
      if (abort_at >= 0 && arr_clr_en && arr_index == abort_at[13:0]) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "/reset_outputs"}, any_out(), 1'b0);
        aborted = 1;
      end
    end
    chk({nm, "/index_seq"}, bad, 0);
    chk({nm, "/other_ops"}, other, 0);
    if (abort_at < 0) begin
      chk({nm, "/done_cnt"}, ndone, 1);
      chk({nm, "/clr_cycles"}, exp_ix, 16384);
      chk({nm, "/done_on_last"}, last_ok, 1'b1);
      @(negedge clk);
      chk({nm, "/after_done"}, {done, busy, arr_clr_en}, 3'b000);
    end else begin
      chk({nm, "/aborted"}, aborted, 1'b1);
      chk({nm, "/abort_idx"}, exp_ix, abort_at + 1);
      repeat (2) @(negedge clk);
      chk({nm, "/held_reset"}, any_out(), 1'b0);
      rst_n = 1'b1;
      bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (arr_clr_en || done || busy || arr_wr_en) bad++;
      end
      chk({nm, "/post_reset_quiet"}, bad, 0);
      chk({nm, "/post_reset_ready"}, cmd_ready, 1'b1);
    end
  endtask

  initial begin
    logic [3:0]  code;
    logic        hit;
    logic [1:0]  hst;
    int          r;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 0; cmd_addr = 0;
    arr_hit = 0; arr_hit_way = 0; arr_hit_state = 0;
    arr_vic_way = 0; arr_vic_state = 0; arr_vic_tag = 0;
    bus_ready = 1'b0; print_done = 1'b0;
    #3;
    chk("reset_outputs", any_out(), 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", {busy, cmd_ready}, 2'b01);

    run_cmd("rd_miss_vicI_S", 4'd0, 32'h10019D94, 1'b0, MI, 4'd0, MI, 4'd3, 12'h055, 0);
    run_cmd("rd_miss_vicI_E", 4'd0, 32'h10019D96, 1'b0, MI, 4'd0, MS, 4'd7, 12'h055, 1);
    run_cmd("rd_miss_vicM", 4'd0, 32'h10019D95, 1'b0, MI, 4'd0, MM, 4'd9, 12'h2AB, 8);
    run_cmd("ifetch_hit", 4'd2, 32'h10019D94, 1'b1, ME, 4'd5, MM, 4'd1, 12'h2AB, 0);
    run_cmd("wr_hit_S", 4'd1, 32'h10019D94, 1'b1, MS, 4'd3, MI, 4'd0, 12'h000, 2);
    run_cmd("wr_hit_E", 4'd1, 32'h10019D94, 1'b1, ME, 4'd3, MI, 4'd0, 12'h000, 0);
    run_cmd("wr_miss_vicM", 4'd1, 32'h7FFFFFC1, 1'b0, MI, 4'd0, MM, 4'd15, 12'hFFF, 3);
    run_cmd("snp_rwim_M", 4'd6, 32'h10019D94, 1'b1, MM, 4'd3, MI, 4'd0, 12'h000, 4);
    run_cmd("snp_rd_miss", 4'd4, 32'h10019D94, 1'b0, MI, 4'd0, MM, 4'd2, 12'h123, 0);
    run_cmd("snp_inval_S", 4'd3, 32'h00000040, 1'b1, MS, 4'd8, MI, 4'd0, 12'h000, 0);
    run_cmd("code7", 4'd7, 32'h10019D94, 1'b1, MM, 4'd3, MM, 4'd3, 12'h2AB, 0);
    run_cmd("print", 4'd9, 32'h00000000, 1'b0, MI, 4'd0, MI, 4'd0, 12'h000, 0);

    run_clear("clear_full", -1);
    run_clear("clear_reset", 'h100);

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 15);
      if (r < 12)       code = 4'(r % 7);
      else if (r == 12) code = 4'd9;
      else if (r == 13) code = 4'd7;
      else              code = 4'($urandom_range(10, 15));
      hit = 1'($urandom_range(0, 1));
      hst = hit ? 2'($urandom_range(1, 3)) : MI;
      run_cmd($sformatf("rnd%0d_c%0d", i, code), code, $urandom, hit, hst,
              4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)),
              $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/llc_cmd_sequencer.md
Name: llc_cmd_sequencer

Overview:
- Sequences one last-level-cache (LLC) command at a time from the trace reader against an external tag/MESI array.
- Splits each address into tag/index/byte select, looks up the array, issues bus operations (writeback, read, invalidate, RWIM) and reports its own snoop result.
- Updates MESI state and performs clear and print operations.
- Sits between the trace-driven stimulus and the cache storage/bus models.

Parameters:
- ADDR_W, 32, address width.
- INDEX_W, 14, set index bits.
- OFFSET_W, 6, byte-select bits (64 B line). TAG_W = ADDR_W-INDEX_W-OFFSET_W (12).
- WAY_W, 4, way-number width (16 ways).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_code  in  4  0 rd, 1 wr, 2 ifetch, 3 snp_inval, 4 snp_rd, 5 snp_wr, 6 snp_rwim, 8 clear, 9 print
- cmd_addr  in  ADDR_W  command address
- arr_rd_en, arr_index, arr_tag  out  1, INDEX_W, TAG_W  lookup request
- arr_hit, arr_hit_way, arr_hit_state  in  1, WAY_W, 2  lookup result; MESI encoding I=0, S=1, E=2, M=3
- arr_vic_way, arr_vic_state, arr_vic_tag  in  WAY_W, 2, TAG_W  PLRU victim
- arr_wr_en, arr_wr_way, arr_wr_tag, arr_wr_state  out  1, WAY_W, TAG_W, 2  line write plus LRU touch; index = arr_index
- arr_clr_en  out  1  invalidate all ways of arr_index, reset its PLRU
- bus_valid / bus_ready  out / in  1 / 1  bus handshake
- bus_op  out  3  1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM
- bus_addr  out  ADDR_W  line-aligned address (offset bits 0)
- snp_valid, snp_result  out  1, 2  own snoop result: HIT=0, HITM=1, NOHIT=2
- print_req / print_done  out / in  1 / 1  print handshake
- done, err, busy  out  1  completion pulse, illegal-code pulse, not-IDLE

Behaviour:
- Reset:
  - Asynchronous; FSM goes to IDLE and every output is 0, including cmd_ready.
  - A reset mid-operation aborts the operation, a bus op and a clear walk; no further writes are issued.
- States: IDLE, LOOKUP, DECIDE, WB, BUSOP, UPDATE, CLEAR, PRINT.
- IDLE:
  - cmd_ready=1. On handshake, latch code/addr.
  - Codes 0-6 go to LOOKUP; 8 goes to CLEAR with index counter 0; 9 goes to PRINT.
  - Other codes: err=1 and done=1 for one cycle, stay IDLE.
- LOOKUP: arr_rd_en=1 for 1 cycle. Array results are valid in DECIDE (next cycle).
- Own bus-read result (bus snoop of other caches): addr[1:0] 00 gives HIT, 01 gives HITM, 10/11 give NOHIT. HIT/HITM fill S, NOHIT fills E.
- Read/ifetch (0/2):
  - Hit: UPDATE with same state (LRU touch).
  - Miss: if victim M go to WB, then BUSOP READ, then UPDATE. Fill tag, victim way, state per own-read result.
- Write (1):
  - Hit M/E: UPDATE to M.
  - Hit S: BUSOP INVALIDATE, then M.
  - Miss: optional WB, then BUSOP RWIM, fill M.
- Snooped commands: DECIDE pulses snp_valid. The result is HITM if hit M, HIT if hit E/S, else NOHIT.
  - 3 snp_inval: hit S goes to I.
  - 4 snp_rd: M does WB of the hit line, then S; E goes to S; S unchanged.
  - 5 snp_wr: no change.
  - 6 snp_rwim: M does WB, then I; E/S go to I.
  - Snooped commands do not touch LRU: arr_wr_en only on a state change, with the same tag.
- WB: bus_op=WRITE, bus_addr={victim or hit tag, index, 0}.
- Bus handshake: bus_valid held with op/addr stable until the bus_ready edge; the op completes on that edge.
- UPDATE: arr_wr_en=1 one cycle, done=1 the same cycle, then IDLE.
- Latency: a read hit pulses done 3 cycles after the accept edge.
- CLEAR:
  - arr_clr_en=1 with arr_index=counter each cycle, for 2^INDEX_W cycles.
  - Counter wraps at the final index; done on the last cycle, then IDLE.
- PRINT: print_req held until print_done, then done, then IDLE.
- Mutual exclusion: only one of arr_rd_en, arr_wr_en, arr_clr_en is active per cycle; bus_valid is never asserted outside WB/BUSOP.
- busy = state != IDLE.

Test Plan:
- Read miss, victim I: rd 0x10019D94 → arr_index 0x676, tag 0x100; bus READ 0x10019D80; write state S (addr[1:0]=00 gives HIT); done. Repeat with 0x10019D96 → state E.
- Read miss, victim M tag 0x2AB: rd 0x10019D95 → bus WRITE 0x2AB19D80, then READ 0x10019D80; fill S (HITM). Holding bus_ready=0 for 5 cycles keeps bus_valid and bus_addr stable.
- Write hit S at 0x10019D94 → bus INVALIDATE 0x10019D80, state M; write hit E → no bus op, M, done 3 cycles after accept.
- Snoop RWIM (6) hitting M → snp_result HITM, bus WRITE 0x10019D80, state I. Snoop rd on miss → NOHIT, no writes.
- Clear (8) → arr_clr_en for 16384 cycles, indices 0x0000..0x3FFF, single done. Rerun with rst_n low at index 0x100 → all outputs 0 immediately, IDLE, cmd_ready=1 after release.
- Code 7 → err and done pulse, no array/bus activity. Print (9) with print_done after 4 cycles → done follows.
